vedic_product_accumulator: RTL and testbench
============================================

// Module: vedic_product_accumulator
// PURPOSE
// - Downstream consumer of the 4x4 Vedic multiplier's 8-bit product.
// - Accumulates a stream of unsigned products into one sum (dot-product / MAC use).
// - A result is emitted when ACC_LEN products are taken, or earlier when in_last is set.
// - Valid/ready handshake on both sides.
//   - Input side: in_valid / in_ready.
//   - Output side: out_valid / out_ready.
// PARAMETERS
// - ACC_LEN  16  products per full accumulation; legal range 2..256.
// - ACC_W    12  accumulator/result width; must be >= 8 + $clog2(ACC_LEN). Elaboration error if not.
// - CNT_W    localparam = $clog2(ACC_LEN+1); width of the count fields.
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous active-low reset
// - clr         in   1       synchronous discard of the partial sum
// - in_valid    in   1       in_product is valid this cycle
// - in_ready    out  1       block accepts in_product this cycle
// - in_product  in   8       unsigned product, 0..225
// - in_last     in   1       qualified by in_valid: this product closes the sum
// - out_valid   out  1       out_sum / out_count are valid
// - out_ready   in   1       consumer takes the result
// - out_sum     out  ACC_W   accumulated sum
// - out_count   out  CNT_W   number of products in out_sum, 1..ACC_LEN
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous):
//   - state=ACCUM; acc=0; cnt=0.
//   - out_valid=0; out_sum=0; out_count=0.
//   - in_ready goes to 1 after reset deasserts.
// - States: ACCUM and HOLD. in_ready = (state==ACCUM) && !clr. A beat is accepted when in_valid && in_ready.
// - ACCUM, accepted beat, not closing:
//   - acc <= acc + in_product (zero-extended).
//   - cnt <= cnt + 1.
// - ACCUM, closing beat (accepted && (in_last || cnt==ACC_LEN-1)):
//   - out_sum <= acc + in_product; out_count <= cnt + 1.
//   - out_valid <= 1; acc <= 0; cnt <= 0; -> HOLD.
//   - Latency: the result is visible one cycle after the closing beat.
// - ACCUM, clr=1:
//   - acc <= 0; cnt <= 0.
//   - in_ready=0, so any simultaneous input beat is not accepted.
// - HOLD:
//   - in_ready=0; out_sum, out_count and out_valid are held stable.
//   - clr is ignored.
//   - When out_ready=1: out_valid <= 0, -> ACCUM. The first new beat can be accepted the next cycle.
// - out_valid never deasserts without out_ready. out_sum and out_count keep their last value after the handshake.
// - Arithmetic: unsigned, no saturation. The ACC_W constraint makes overflow impossible (16*225 = 3600 < 4096).
// - in_valid=0 cycles in ACCUM are idle; acc and cnt are held. Gaps between beats are allowed.
// - in_last on the first beat gives out_count=1 and out_sum=in_product.
// - rst_n asserted mid-accumulation or in HOLD returns every register to its reset value at once.
//   - The partial or held result is lost.
// TESTING
// - Full run: 16 beats of 225, out_ready=1.
//   - out_valid exactly 1 cycle after the 16th beat; out_sum=3600; out_count=16.
// - Early close: beats 10, 20, 30 with in_last on 30.
//   - out_sum=60; out_count=3; in_ready=0 until out_ready is seen.
// - Backpressure: result 0x0F0 pending, out_ready=0 for 5 cycles.
//   - out_valid/out_sum stable, in_ready=0, in_valid pulses ignored.
//   - out_ready=1 -> ACCUM next cycle.
// - Clear: beats 5, 7 then clr=1 with in_valid=1, product 9; then beat 4 with in_last.
//   - out_sum=4; out_count=1.
// - Reset mid-run: 8 beats of 100, then rst_n=0 for 2 cycles.
//   - All outputs 0. Next 16 beats of 1 -> out_sum=16.
// - Random: 10k beats with random in_valid, in_last, out_ready and products 0..225.
//   - Results match a scoreboard model of the summed products.
//   - No beat is accepted in HOLD.

Source files
------------

// File: rtl/vedic_product_accumulator.sv
// Accumulates a stream of unsigned 8-bit Vedic multiplier products into one sum and
// emits the result after ACC_LEN products or on in_last, with valid/ready on both sides.
module vedic_product_accumulator #(
   parameter int unsigned ACC_LEN = 16,
   parameter int unsigned ACC_W   = 12,
   localparam int unsigned CNT_W  = $clog2(ACC_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count
);

   if (ACC_LEN < 2 || ACC_LEN > 256) begin : g_bad_len
      $error("vedic_product_accumulator: ACC_LEN must be in 2..256");
   end
   if (ACC_W < 8 + $clog2(ACC_LEN)) begin : g_bad_width
      $error("vedic_product_accumulator: ACC_W too narrow for ACC_LEN products");
   end

   typedef enum logic {StAccum, StHold} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             closing;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      in_ready = (state == StAccum) && !clr;
      accept   = in_valid && in_ready;
      acc_next = acc + ACC_W'(in_product);
      cnt_next = cnt + CNT_W'(1);
      closing  = accept && (in_last || (cnt == CNT_W'(ACC_LEN - 1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StAccum;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
      end else begin
         unique case (state)
            StAccum: begin
               if (clr) begin
                  acc <= '0;
                  cnt <= '0;
               end else if (closing) begin
                  out_sum   <= acc_next;
                  out_count <= cnt_next;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= StHold;
               end else if (accept) begin
                  acc <= acc_next;
                  cnt <= cnt_next;
               end
            end
            StHold: begin
               // Result registers stay frozen; only the consumer handshake moves us on.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StAccum;
               end
            end
            default: state <= StAccum;
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_product_accumulator.sv
// Self-checking bench for vedic_product_accumulator: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_vedic_product_accumulator;

   localparam int ACC_LEN = 16;
   localparam int ACC_W   = 12;
   localparam int CNT_W   = $clog2(ACC_LEN + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_product;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;

   int checks   = 0;
   int failures = 0;

   vedic_product_accumulator #(
      .ACC_LEN(ACC_LEN),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_product(in_product),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int p;
      bit l;
      bit c;
      bit r;
      bit rdy;
      bit ov;
      int sum;
      int cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input int p, input bit l, input bit c, input bit r);
      in_valid   = v;
      in_product = 8'(p);
      in_last    = l;
      clr        = c;
      out_ready  = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input bit ov, input int sum, input int cnt);
      check({name, "_out_valid"}, 32'(out_valid), 32'(ov));
      check({name, "_out_sum"}, 32'(out_sum), 32'(sum));
      check({name, "_out_count"}, 32'(out_count), 32'(cnt));
   endtask

   // Reference model state for the random run.
   bit hold;
   int q[$];
   int last_sum;
   int last_cnt;

   initial begin
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 0, 0, 0);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);

      //                v  p    l  c  r  rdy ov sum cnt
      tbl.push_back('{1, 10,  0, 0, 0, 1,  0, 0,   0});
      tbl.push_back('{1, 20,  0, 0, 0, 1,  0, 0,   0});
      tbl.push_back('{1, 30,  1, 0, 0, 1,  1, 60,  3});
      tbl.push_back('{1, 99,  0, 0, 0, 0,  1, 60,  3});
      tbl.push_back('{0, 0,   0, 0, 1, 0,  0, 60,  3});
      tbl.push_back('{1, 5,   0, 0, 0, 1,  0, 60,  3});
      tbl.push_back('{1, 7,   0, 0, 0, 1,  0, 60,  3});
      tbl.push_back('{1, 9,   0, 1, 0, 0,  0, 60,  3});
      tbl.push_back('{1, 4,   1, 0, 0, 1,  1, 4,   1});
      tbl.push_back('{0, 0,   0, 0, 1, 0,  0, 4,   1});
      tbl.push_back('{0, 0,   0, 1, 0, 0,  0, 4,   1});
      tbl.push_back('{1, 200, 0, 0, 0, 1,  0, 4,   1});
      tbl.push_back('{1, 40,  1, 0, 0, 1,  1, 240, 2});
      tbl.push_back('{1, 77,  1, 0, 0, 0,  1, 240, 2});
      tbl.push_back('{0, 77,  0, 1, 0, 0,  1, 240, 2});
      tbl.push_back('{1, 77,  1, 0, 0, 0,  1, 240, 2});
      tbl.push_back('{0, 77,  0, 1, 0, 0,  1, 240, 2});
      tbl.push_back('{1, 77,  1, 0, 0, 0,  1, 240, 2});
      tbl.push_back('{0, 0,   0, 0, 1, 0,  0, 240, 2});
      tbl.push_back('{1, 1,   1, 0, 0, 1,  1, 1,   1});
      tbl.push_back('{0, 0,   0, 0, 1, 0,  0, 1,   1});

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].c, tbl[i].r);
         #1;
         check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         tick();
         check_out($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].sum, tbl[i].cnt);
      end

      // Full run: result appears exactly one cycle after the 16th beat.
      for (int i = 0; i < ACC_LEN; i++) begin
         drive(1, 225, 0, 0, 1);
         #1;
         check("full_in_ready", 32'(in_ready), 32'd1);
         tick();
         if (i < ACC_LEN - 1) check("full_early_valid", 32'(out_valid), 32'd0);
      end
      check_out("full", 1, 3600, 16);
      drive(0, 0, 0, 0, 1);
      tick();
      check_out("full_after", 0, 3600, 16);

      // Reset mid-accumulation wipes everything asynchronously.
      for (int i = 0; i < 8; i++) begin
         drive(1, 100, 0, 0, 0);
         tick();
      end
      check_out("midrun_before_reset", 0, 3600, 16);
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 0, 0, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < ACC_LEN; i++) begin
         drive(1, 1, 0, 0, 0);
         tick();
      end
      check_out("post_reset", 1, 16, 16);
      drive(0, 0, 0, 0, 1);
      tick();

      // Random run against the queue model, from a clean reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      hold     = 1'b0;
      last_sum = 0;
      last_cnt = 0;
      q.delete();
      for (int n = 0; n < 10000; n++) begin
         bit v, l, c, r;
         int p;
         v = ($urandom_range(0, 99) < 70);
         p = int'($urandom_range(0, 225));
         l = ($urandom_range(0, 99) < 15);
         c = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 99) < 50);
         drive(v, p, l, c, r);
         #1;
         check("rnd_in_ready", 32'(in_ready), 32'(!hold && !c));
         if (hold) begin
            if (r) hold = 1'b0;
         end else if (c) begin
            q.delete();
         end else if (v) begin
            q.push_back(p);
            if (l || q.size() == ACC_LEN) begin
               int s;
               s = 0;
               foreach (q[k]) s += q[k];
               last_sum = s;
               last_cnt = q.size();
               q.delete();
               hold = 1'b1;
            end
         end
         tick();
         check_out("rnd", hold, last_sum, last_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
